finv_iter: RTL

//  Sequential single-precision reciprocal (d = 1/s) for the FPU.

---
 rtl/finv_iter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/finv_iter.sv
`timescale 1ns/1ps
// finv_iter: sequential IEEE-754 single-precision reciprocal, d = 1/s.
// A linear seed is refined by ITER Newton-Raphson steps on an unsigned fixed-point
// datapath with FRAC_W fraction bits and 2 integer bits. One shared multiplier
// serves the seed and both halves of each iteration. Special operands bypass the
// iteration and produce their result one cycle after acceptance.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   operand i_s is valid
//   o_in_ready   block accepts an operand (IDLE only, and only while i_rst is low)
//   i_s          IEEE-754 single operand
//   o_out_valid  o_d / o_overflow / o_underflow are valid
//   i_out_ready  consumer takes the result
//   o_d          IEEE-754 single result
//   o_overflow   divide-by-zero: operand was zero or denormal
//   o_underflow  result flushed to zero
module finv_iter #(
  parameter int unsigned ITER   = 3,
  parameter int unsigned FRAC_W = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_s,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_d,
  output logic        o_overflow,
  output logic        o_underflow
);

  localparam int unsigned XW = FRAC_W + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEED = 3'd1;
  localparam logic [2:0] S_MUL1 = 3'd2;
  localparam logic [2:0] S_MUL2 = 3'd3;
  localparam logic [2:0] S_NORM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Seed constants 48/17 and 32/17, truncated to FRAC_W fraction bits.
  localparam logic [63:0]   C48_FULL  = (64'd48 << FRAC_W) / 64'd17;
  localparam logic [63:0]   C32_FULL  = (64'd32 << FRAC_W) / 64'd17;
  localparam logic [XW-1:0] C48       = C48_FULL[XW-1:0];
  localparam logic [XW-1:0] C32       = C32_FULL[XW-1:0];
  localparam logic [XW-1:0] TWO       = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [2:0]    LAST_ITER = 3'(ITER - 1);

  logic [2:0]    r_state;
  logic [2:0]    r_iter;
  logic          r_sign;
  logic [7:0]    r_exp;
  logic [XW-1:0] r_dfix;
  logic [XW-1:0] r_x;
  logic [XW-1:0] r_t;
  logic [31:0]   r_d;
  logic          r_ovf;
  logic          r_unf;
  logic          r_out_valid;

  logic          w_sg;
  logic [7:0]    w_e;
  logic [22:0]   w_m;
  logic          w_special;
  logic [31:0]   w_spec_d;
  logic          w_spec_ovf;
  logic          w_spec_unf;
  logic [XW-1:0] w_dfix;
  logic [XW-1:0] w_mul_a;
  logic [XW-1:0] w_mul_b;
  logic [2*XW-1:0] w_prod;
  logic [XW-1:0] w_prod_t;
  logic [23:0]   w_rsum;
  logic [31:0]   w_norm_d;

  assign w_sg = i_s[31];
  assign w_e  = i_s[30:23];
  assign w_m  = i_s[22:0];

  // Operands whose result needs no iteration (or cannot be a normal number).
  always_comb begin
    w_special  = 1'b1;
    w_spec_d   = 32'd0;
    w_spec_ovf = 1'b0;
    w_spec_unf = 1'b0;
    if (w_e == 8'd0) begin
      w_spec_d   = {w_sg, 8'hFF, 23'd0};
      w_spec_ovf = 1'b1;
    end else if (w_e == 8'hFF) begin
      w_spec_d = (w_m == 23'd0) ? {w_sg, 31'd0} : 32'h7FC0_0000;
    end else if (w_m == 23'd0) begin
      if (w_e == 8'd254) begin
        w_spec_d   = {w_sg, 31'd0};
        w_spec_unf = 1'b1;
      end else begin
        w_spec_d = {w_sg, 8'd254 - w_e, 23'd0};
      end
    end else if (w_e >= 8'd253) begin
      w_spec_d   = {w_sg, 31'd0};
      w_spec_unf = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  // D = 1.m / 2 in [0.5, 1) with FRAC_W fraction bits.
  assign w_dfix = XW'({1'b1, w_m}) << (FRAC_W - 24);

  // Shared multiplier operand selection.
  always_comb begin
    w_mul_a = r_dfix;
    w_mul_b = r_x;
    case (r_state)
      S_SEED: begin
        w_mul_a = C32;
        w_mul_b = r_dfix;
      end
      S_MUL2: begin
        w_mul_a = r_x;
        w_mul_b = TWO - r_t;
      end
      default: begin
        w_mul_a = r_dfix;
        w_mul_b = r_x;
      end
    endcase
  end

  assign w_prod   = {{XW{1'b0}}, w_mul_a} * {{XW{1'b0}}, w_mul_b};
  assign w_prod_t = XW'(w_prod >> FRAC_W);

  // x is in (1,2): mantissa is the top 23 fraction bits, rounded half-up.
  assign w_rsum   = {1'b0, r_x[FRAC_W-1 -: 23]} + {23'd0, r_x[FRAC_W-24]};
  assign w_norm_d = w_rsum[23] ? {r_sign, 8'd254 - r_exp, 23'd0}
                               : {r_sign, 8'd253 - r_exp, w_rsum[22:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_iter      <= 3'd0;
      r_sign      <= 1'b0;
      r_exp       <= 8'd0;
      r_dfix      <= '0;
      r_x         <= '0;
      r_t         <= '0;
      r_d         <= 32'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_sign <= w_sg;
            r_exp  <= w_e;
            r_dfix <= w_dfix;
            r_iter <= 3'd0;
            if (w_special) begin
              r_d         <= w_spec_d;
              r_ovf       <= w_spec_ovf;
              r_unf       <= w_spec_unf;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_SEED;
            end
          end
        end
        S_SEED: begin
          r_x     <= C48 - w_prod_t;
          r_state <= S_MUL1;
        end
        S_MUL1: begin
          r_t     <= w_prod_t;
          r_state <= S_MUL2;
        end
        S_MUL2: begin
          r_x <= w_prod_t;
          if (r_iter == LAST_ITER) begin
            r_state <= S_NORM;
          end else begin
            r_iter  <= r_iter + 3'd1;
            r_state <= S_MUL1;
          end
        end
        S_NORM: begin
          r_d         <= w_norm_d;
          r_ovf       <= 1'b0;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE) && !i_rst;
  assign o_out_valid = r_out_valid;
  assign o_d         = r_d;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule
